encoding_tree_pipe: RTL
=======================

// Module: encoding_tree_pipe
// PURPOSE
//  Pipelined, parametrised leading-one encoder for the LZA normalisation path.
//  Returns the MSB-relative position of the first significant bit (shift amount) and a not-zero flag.
//  Mode selects counting leading zeros or leading ones.
//  Valid/ready streaming, sideband tag, configurable register density; sits between LZA string generation and the normalising shifter.
// PARAMETERS
//  DATA_WIDTH        8   input string width, any value >=2; internally zero-padded at LSB to P = 2**SHIFT_WIDTH
//  SHIFT_WIDTH       $clog2(DATA_WIDTH)  width of nshift; derived, do not override
//  LEVELS_PER_STAGE  1   merge-tree levels per pipeline register, 1..SHIFT_WIDTH
//  TAG_WIDTH         4   sideband tag carried alongside each item, >=1
// PORTS
//  clk           in   1            clock, all state on rising edge
//  rst_n         in   1            asynchronous active-low reset
//  flush         in   1            synchronous: drop all in-flight items
//  in_valid      in   1            input item present
//  in_ready      out  1            block accepts item this cycle
//  in_data       in   DATA_WIDTH   string_f, bit DATA_WIDTH-1 is MSB
//  in_mode       in   1            0: find first 1 from MSB; 1: find first 0 from MSB
//  in_tag        in   TAG_WIDTH    opaque sideband
//  out_valid     out  1            result present
//  out_ready     in   1            consumer accepts result
//  out_nshift    out  SHIFT_WIDTH  count of leading zeros (mode0) / leading ones (mode1)
//  out_not_zero  out  1            1 if a significant bit was found
//  out_tag       out  TAG_WIDTH    in_tag of the same item
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all stage valids = 0.
//    out_valid=0, out_nshift=0, out_not_zero=0, out_tag=0.
//  - Front end: s = in_mode ? ~in_data : in_data; then pad to P bits with zeros at LSB.
//  - Tree: SHIFT_WIDTH levels of 2-input merge nodes.
//    Node(hi,lo): nz = nz_hi|nz_lo; pos = nz_hi ? {0,pos_hi} : {1,pos_lo}.
//  - Register placement: STAGES = ceil(SHIFT_WIDTH/LEVELS_PER_STAGE).
//    A register follows every LEVELS_PER_STAGE levels, and the last level is always registered.
//  - Latency: STAGES cycles from accepted input to out_valid, when unstalled.
//  - Throughput: one item/cycle when out_ready=1.
//  - Handshake: a transfer happens when valid&ready on that side.
//    Stage k loads when !valid_k or stage k+1 loads, with the last stage loading when !out_valid or out_ready.
//    in_ready = load condition of stage 0, a combinational chain from out_ready.
//  - Outputs stay stable while out_valid=1 and out_ready=0; items are never dropped or duplicated.
//  - All-zero significant string (mode0 all 0s, mode1 all 1s): out_not_zero=0, out_nshift=0.
//  - Padding bits never win: a result of DATA_WIDTH or more is impossible when not_zero=1.
//  - flush=1: all valids cleared next edge, in_ready=0 that cycle, flush wins over simultaneous accept.
//  - Data/tag registers are loaded only on stage load (not reset-dependent beyond outputs above).
//  - Mode and tag travel with their item; mixed modes back-to-back are legal.
// STRUCTURE
//  - Shared package lza_pkg: function clog2_min1, typedef for the node result {nz, pos}, and PAD_WIDTH helper.
//  - One sub-module: lod_merge_node (combinational, parameter POS_WIDTH), instantiated by generate per level/node.
//  - Top holds front-end inversion/padding, the per-stage valid/data registers and the handshake chain.
// TESTING
//  - T1 DATA_WIDTH=8, LPS=1 (3 stages): in 8'b0001_0110, mode0, tag 5.
//    -> out after 3 cycles: nshift=3, not_zero=1, tag=5.
//  - T2 mode1, in 8'b1110_0000 -> nshift=3, nz=1; in 8'hFF mode1 -> nshift=0, nz=0; in 8'h00 mode0 -> nshift=0, nz=0.
//  - T3 DATA_WIDTH=12, in 12'h001 mode0 -> nshift=11, nz=1.
//    in 12'h800 -> nshift=0; padding never yields >=12.
//  - T4 Stream 8 items back-to-back, out_ready=1 -> 8 results on consecutive cycles, in order.
//    Then toggle out_ready pseudo-randomly -> same sequence, outputs held while stalled, no loss.
//  - T5 Fill pipe with out_ready=0 -> in_ready=0 after STAGES+... accepts exactly STAGES items.
//    Then assert flush with in_valid=1 -> next cycle out_valid=0, nothing accepted.
//  - T6 Assert rst_n=0 mid-stream (asynchronous, off clock edge) -> out_valid=0, outputs zero immediately.
//    After release, first new item returns with correct latency.

Source files
------------

// File: rtl/lza_pkg.sv
// Shared types and sizing helpers for the leading-one encoder tree.
package lza_pkg;

    localparam int unsigned MAX_POS_WIDTH = 16;

    typedef struct packed {
        logic                     nz;
        logic [MAX_POS_WIDTH-1:0] pos;
    } lod_node_t;

    // Width of the shift amount; never zero so a 2-bit string still gets a 1-bit result.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned pad_width(input int unsigned dw);
        return (32'd1 << clog2_min1(dw)) - dw;
    endfunction

endpackage

// File: rtl/lod_merge_node.sv
// Two-input merge of the leading-one tree: picks the upper half when it holds a one.
module lod_merge_node #(
    parameter int unsigned POS_WIDTH = 3,
    parameter int unsigned LEVEL     = 0
) (
    input  logic                 nz_hi_i,
    input  logic                 nz_lo_i,
    input  logic [POS_WIDTH-1:0] pos_hi_i,
    input  logic [POS_WIDTH-1:0] pos_lo_i,
    output logic                 nz_o,
    output logic [POS_WIDTH-1:0] pos_o
);

    // Inputs only carry bits below LEVEL, so OR-ing in this bit is the {1,pos_lo} concat.
    localparam logic [POS_WIDTH-1:0] LevelBit = POS_WIDTH'(1) << LEVEL;

    assign nz_o  = nz_hi_i | nz_lo_i;
    assign pos_o = nz_hi_i ? pos_hi_i : (pos_lo_i | LevelBit);

endmodule

// File: rtl/encoding_tree_pipe.sv
// Pipelined leading-zero/leading-one counter with valid/ready streaming and a sideband tag.
module encoding_tree_pipe
    import lza_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned SHIFT_WIDTH      = clog2_min1(DATA_WIDTH),
    parameter int unsigned LEVELS_PER_STAGE = 1,
    parameter int unsigned TAG_WIDTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SHIFT_WIDTH-1:0] out_nshift,
    output logic                   out_not_zero,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int unsigned P      = 32'd1 << SHIFT_WIDTH;
    localparam int unsigned PAD    = pad_width(DATA_WIDTH);
    localparam int          STAGES = int'((SHIFT_WIDTH + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE);

    logic [DATA_WIDTH-1:0] s;
    logic [P-1:0]          s_pad;
    logic [STAGES-1:0]     ld;
    logic [STAGES-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q [STAGES];

    assign s     = in_mode ? ~in_data : in_data;
    assign s_pad = P'(s) << PAD;

    // Load chain ripples back from the consumer so a full pipe still moves every cycle.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !valid_q[k] || ld[k+1];
        end
    end

    assign in_ready = ld[0] && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (ld[0]) valid_d[0] = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) valid_d[k] = valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (ld[0]) tag_q[0] <= in_tag;
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) tag_q[k] <= tag_q[k-1];
        end
    end

    // Level l holds P>>l nodes; node 0 always covers the MSB end.
    for (genvar l = 0; l <= SHIFT_WIDTH; l++) begin : g_lvl
        localparam int unsigned N = P >> l;
        logic [N-1:0]             nz;
        logic [SHIFT_WIDTH-1:0]   pos [N];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_bit
                assign nz[j]  = s_pad[P-1-j];
                assign pos[j] = '0;
            end
        end else begin : g_merge
            logic [N-1:0]           nz_m;
            logic [SHIFT_WIDTH-1:0] pos_m [N];

            for (genvar j = 0; j < N; j++) begin : g_node
                lod_merge_node #(
                    .POS_WIDTH (SHIFT_WIDTH),
                    .LEVEL     (l - 1)
                ) u_node (
                    .nz_hi_i  (g_lvl[l-1].nz[2*j]),
                    .nz_lo_i  (g_lvl[l-1].nz[2*j+1]),
                    .pos_hi_i (g_lvl[l-1].pos[2*j]),
                    .pos_lo_i (g_lvl[l-1].pos[2*j+1]),
                    .nz_o     (nz_m[j]),
                    .pos_o    (pos_m[j])
                );
            end

            if ((l % LEVELS_PER_STAGE == 0) || (l == SHIFT_WIDTH)) begin : g_reg
                localparam int unsigned S = (l + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE - 1;
                always_ff @(posedge clk) begin
                    if (ld[S]) begin
                        nz  <= nz_m;
                        pos <= pos_m;
                    end
                end
            end else begin : g_comb
                assign nz  = nz_m;
                assign pos = pos_m;
            end
        end
    end

    // Outputs are gated by valid so reset and empty slots read as zero.
    assign out_valid    = valid_q[STAGES-1];
    assign out_not_zero = out_valid && g_lvl[SHIFT_WIDTH].nz[0];
    assign out_nshift   = out_not_zero ? g_lvl[SHIFT_WIDTH].pos[0] : '0;
    assign out_tag      = out_valid ? tag_q[STAGES-1] : '0;

endmodule
